// File: rtl/display_pkg.sv
// Shared display definitions: pixel bus width and the VGA receiver lock states.
package display_pkg;

  localparam int RGB_W = 12;

  typedef enum logic [1:0] {
    UNLOCKED,
    TRACK,
    LOCKED
  } vga_rx_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Registers one sync pin, normalises it to active-high and flags its
// leading (0->1) and trailing (1->0) edges from the registered history.
module sync_edge_det #(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sync,
  output logic lead,
  output logic trail
);

  logic cur;
  logic prev;

  // Reset history is "deasserted" so the first real pulse shows up as a leading edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur  <= 1'b0;
      prev <= 1'b0;
    end else begin
      cur  <= sync ^ ACTIVE_LOW;
      prev <= cur;
    end
  end

  assign lead  = cur & ~prev;
  assign trail = ~cur & prev;

endmodule

// File: rtl/vga_timing_rx.sv
// Receive-side VGA timing recovery: measures line/frame geometry from HS/VS,
// regenerates pixel coordinates and reports when the timing is stable.
module vga_timing_rx
  import display_pkg::*;
#(
  parameter int RGB_W         = display_pkg::RGB_W,
  parameter int CNT_W         = 12,
  parameter bit HS_ACTIVE_LOW = 1'b1,
  parameter bit VS_ACTIVE_LOW = 1'b1,
  parameter int LOCK_FRAMES   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [RGB_W-1:0] vga_rgb,
  input  logic             vga_hs,
  input  logic             vga_vs,
  output logic [RGB_W-1:0] rgb_o,
  output logic [CNT_W-1:0] x_o,
  output logic [CNT_W-1:0] y_o,
  output logic             frame_start_o,
  output logic [CNT_W-1:0] h_total_o,
  output logic [CNT_W-1:0] v_total_o,
  output logic             locked_o,
  output logic             sync_err_o
);

  localparam int MATCH_W = $clog2(LOCK_FRAMES + 1);
  localparam logic [CNT_W-1:0]   CNT_MAX    = '1;
  localparam logic [MATCH_W-1:0] MATCH_GOAL = MATCH_W'(LOCK_FRAMES);

  logic [RGB_W-1:0]   rgb_s1;
  logic               hs_lead, hs_trail, vs_lead, vs_trail;
  logic [CNT_W-1:0]   h_cnt, line_cnt, h_ref, v_ref;
  logic [CNT_W-1:0]   h_cnt_inc, line_next;
  logic [CNT_W-1:0]   h_cur, v_cur;
  logic               h_sat, h_bad, v_bad;
  logic               ref_load, sync_err_nxt;
  logic [MATCH_W-1:0] match_cnt, match_nxt, match_inc;
  vga_rx_state_t      state, state_nxt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  sync_edge_det #(.ACTIVE_LOW(HS_ACTIVE_LOW)) u_hs_det (
    .clk   (clk),
    .rst_n (rst_n),
    .sync  (vga_hs),
    .lead  (hs_lead),
    .trail (hs_trail)
  );

  sync_edge_det #(.ACTIVE_LOW(VS_ACTIVE_LOW)) u_vs_det (
    .clk   (clk),
    .rst_n (rst_n),
    .sync  (vga_vs),
    .lead  (vs_lead),
    .trail (vs_trail)
  );

  // A VS edge coinciding with an HS edge must see the line that HS just closed.
  assign h_cnt_inc = sat_inc(h_cnt);
  assign line_next = hs_lead ? sat_inc(line_cnt) : line_cnt;
  assign h_cur     = hs_lead ? h_cnt_inc : h_total_o;
  assign v_cur     = vs_lead ? line_next : v_total_o;
  assign h_sat     = (h_cnt == CNT_MAX) && !hs_lead;
  assign h_bad     = hs_lead && (h_cnt_inc != h_ref);
  assign v_bad     = vs_lead && (line_next != v_ref);
  assign match_inc = match_cnt + MATCH_W'(1);
  assign locked_o  = (state == LOCKED);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rgb_s1        <= '0;
      rgb_o         <= '0;
      frame_start_o <= 1'b0;
      h_cnt         <= '0;
      line_cnt      <= '0;
      h_total_o     <= '0;
      v_total_o     <= '0;
      x_o           <= '0;
      y_o           <= '0;
    end else begin
      rgb_s1        <= vga_rgb;
      rgb_o         <= rgb_s1;
      frame_start_o <= vs_trail;
      h_cnt         <= hs_lead ? '0 : h_cnt_inc;
      if (hs_lead)
        h_total_o <= h_cnt_inc;
      x_o <= hs_trail ? '0 : sat_inc(x_o);
      if (vs_trail)
        y_o <= '0;
      else if (hs_trail)
        y_o <= sat_inc(y_o);
      if (vs_lead) begin
        v_total_o <= line_next;
        line_cnt  <= '0;
      end else begin
        line_cnt  <= line_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= UNLOCKED;
      match_cnt  <= '0;
      h_ref      <= '0;
      v_ref      <= '0;
      sync_err_o <= 1'b0;
    end else begin
      state      <= state_nxt;
      match_cnt  <= match_nxt;
      sync_err_o <= sync_err_nxt;
      if (ref_load) begin
        h_ref <= h_cur;
        v_ref <= v_cur;
      end
    end
  end

  // Only a loss from LOCKED is an error; failures while acquiring just restart.
  always_comb begin
    state_nxt    = state;
    match_nxt    = match_cnt;
    ref_load     = 1'b0;
    sync_err_nxt = 1'b0;
    unique case (state)
      UNLOCKED: begin
        if (vs_lead) begin
          state_nxt = TRACK;
          ref_load  = 1'b1;
          match_nxt = '0;
        end
      end
      TRACK: begin
        if (h_bad || h_sat) begin
          state_nxt = UNLOCKED;
        end else if (vs_lead) begin
          if (line_next == v_ref) begin
            match_nxt = match_inc;
            if (match_inc == MATCH_GOAL)
              state_nxt = LOCKED;
          end else begin
            ref_load  = 1'b1;
            match_nxt = '0;
          end
        end
      end
      LOCKED: begin
        if (h_bad || v_bad || h_sat) begin
          state_nxt    = UNLOCKED;
          sync_err_nxt = 1'b1;
        end
      end
      default: state_nxt = UNLOCKED;
    endcase
  end

endmodule

// File: tb/tb_vga_timing_rx.sv
// Drives reduced-size VGA frames into an active-low and an active-high receiver
// and compares both every cycle against an event-level reference model.
module tb_vga_timing_rx;

  localparam int RGBW   = display_pkg::RGB_W;
  localparam int CMAX   = 4095;
  localparam int LOCK_N = 2;
  localparam int HS_W   = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [RGBW-1:0] vga_rgb;
  bit              hs_act, vs_act;
  logic            vga_hs, vga_vs, vga_hs_ah, vga_vs_ah;

  logic [RGBW-1:0] rgb_o, rgb_ah;
  logic [11:0]     x_o, y_o, h_total_o, v_total_o, x_ah, y_ah, ht_ah, vt_ah;
  logic            frame_start_o, locked_o, sync_err_o, fs_ah, lk_ah, se_ah;

  int n_assert = 0;
  int n_fail   = 0;
  int err_pulses, frame_cyc, pin_x;

  // Reference model state, expressed as pin-level events.
  bit              mh1, mh2, mv1, mv2;
  logic [RGBW-1:0] m_rgb1;
  int m_hcnt, m_lines, ref_h, ref_v, good_frames, lk_mode;
  int e_rgb, e_x, e_y, e_fs, e_ht, e_vt, e_err, e_lock;

  assign vga_hs    = ~hs_act;
  assign vga_vs    = ~vs_act;
  assign vga_hs_ah = hs_act;
  assign vga_vs_ah = vs_act;

  always #5 clk = ~clk;

  vga_timing_rx dut (
    .clk(clk), .rst_n(rst_n), .vga_rgb(vga_rgb), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .rgb_o(rgb_o), .x_o(x_o), .y_o(y_o), .frame_start_o(frame_start_o),
    .h_total_o(h_total_o), .v_total_o(v_total_o), .locked_o(locked_o),
    .sync_err_o(sync_err_o)
  );

  vga_timing_rx #(.HS_ACTIVE_LOW(1'b0), .VS_ACTIVE_LOW(1'b0)) dut_ah (
    .clk(clk), .rst_n(rst_n), .vga_rgb(vga_rgb), .vga_hs(vga_hs_ah), .vga_vs(vga_vs_ah),
    .rgb_o(rgb_ah), .x_o(x_ah), .y_o(y_ah), .frame_start_o(fs_ah),
    .h_total_o(ht_ah), .v_total_o(vt_ah), .locked_o(lk_ah), .sync_err_o(se_ah)
  );

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic modelStep(input bit rst_low);
    bit hl, ht, vl, vt, starved;
    int hlen, nlines, h_now, v_now;
    if (rst_low) begin
      {mh1, mh2, mv1, mv2} = '0;
      m_rgb1 = '0;
      {m_hcnt, m_lines, ref_h, ref_v, good_frames, lk_mode} = '0;
      {e_rgb, e_x, e_y, e_fs, e_ht, e_vt, e_err, e_lock} = '0;
      return;
    end
    hl = mh1 && !mh2;
    ht = !mh1 && mh2;
    vl = mv1 && !mv2;
    vt = !mv1 && mv2;
    hlen    = sat(m_hcnt);
    nlines  = hl ? sat(m_lines) : m_lines;
    starved = (m_hcnt == CMAX) && !hl;
    h_now   = hl ? hlen : e_ht;
    v_now   = vl ? nlines : e_vt;
    e_err   = 0;
    // Lock rules: reference on first frame, count matching frames, drop on any change.
    case (lk_mode)
      0: if (vl) begin lk_mode = 1; ref_h = h_now; ref_v = v_now; good_frames = 0; end
      1: begin
        if (starved || (hl && hlen != ref_h)) lk_mode = 0;
        else if (vl) begin
          if (nlines == ref_v) begin
            good_frames++;
            if (good_frames == LOCK_N) lk_mode = 2;
          end else begin
            ref_h = h_now; ref_v = v_now; good_frames = 0;
          end
        end
      end
      default: if (starved || (hl && hlen != ref_h) || (vl && nlines != ref_v)) begin
        lk_mode = 0; e_err = 1;
      end
    endcase
    e_lock = (lk_mode == 2) ? 1 : 0;
    e_rgb  = int'(m_rgb1);
    e_fs   = vt ? 1 : 0;
    m_hcnt = hl ? 0 : hlen;
    if (hl) e_ht = hlen;
    e_x = ht ? 0 : sat(e_x);
    if (vt) e_y = 0;
    else if (ht) e_y = sat(e_y);
    if (vl) begin e_vt = nlines; m_lines = 0; end
    else m_lines = nlines;
    mh2 = mh1; mh1 = hs_act;
    mv2 = mv1; mv1 = vs_act;
    m_rgb1 = vga_rgb;
  endtask

  task automatic checkOne(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkSet(input string p, input logic [RGBW-1:0] rgb, input logic [11:0] x,
                          input logic [11:0] y, input logic fs, input logic [11:0] ht,
                          input logic [11:0] vt, input logic lk, input logic se);
    checkOne({p, "rgb"}, 32'(rgb), e_rgb);
    checkOne({p, "x"}, 32'(x), e_x);
    checkOne({p, "y"}, 32'(y), e_y);
    checkOne({p, "frame_start"}, 32'(fs), e_fs);
    checkOne({p, "h_total"}, 32'(ht), e_ht);
    checkOne({p, "v_total"}, 32'(vt), e_vt);
    checkOne({p, "locked"}, 32'(lk), e_lock);
    checkOne({p, "sync_err"}, 32'(se), e_err);
  endtask

  task automatic checkOutput();
    checkSet("al_", rgb_o, x_o, y_o, frame_start_o, h_total_o, v_total_o, locked_o, sync_err_o);
    checkSet("ah_", rgb_ah, x_ah, y_ah, fs_ah, ht_ah, vt_ah, lk_ah, se_ah);
  endtask

  // One pixel clock: drive pins, let the DUT sample, then compare shortly after.
  task automatic applyStimulus(input bit hs_a, input bit vs_a, input logic [RGBW-1:0] rgb);
    hs_act  = hs_a;
    vs_act  = vs_a;
    vga_rgb = rgb;
    @(posedge clk);
    modelStep(!rst_n);
    #1;
    checkOutput();
    if (sync_err_o) err_pulses++;
    if (!rst_n) begin
      checkOne("rst_locked", 32'(locked_o), 0);
      checkOne("rst_h_total", 32'(h_total_o), 0);
      checkOne("rst_x", 32'(x_o), 0);
    end
  endtask

  task automatic driveLine(input int len, input bit vs_a, input bit xpat, input int rst_at);
    for (int c = 0; c < len; c++) begin
      if (c == HS_W) pin_x = 0;
      else pin_x++;
      rst_n = (frame_cyc == rst_at) ? 1'b0 : 1'b1;
      applyStimulus(c < HS_W, vs_a, xpat ? RGBW'(pin_x) : RGBW'($urandom));
      frame_cyc++;
    end
    rst_n = 1'b1;
  endtask

  task automatic driveFrame(input int nlines, input int short_idx, input bit xpat, input int rst_at);
    frame_cyc = 0;
    for (int l = 0; l < nlines; l++)
      driveLine((l == short_idx) ? 19 : 20, l < 2, xpat, rst_at);
  endtask

  task automatic driveIdle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, RGBW'($urandom));
  endtask

  initial begin
    rst_n = 1'b0;
    pin_x = 0;
    err_pulses = 0;
    #1;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, RGBW'($urandom));
    rst_n = 1'b1;
    driveIdle($urandom_range(0, 7));

    $display("[TB] nominal 20x10 timing, pixel data = x");
    driveFrame(10, -1, 1'b1, -1);
    driveFrame(10, -1, 1'b1, -1);
    checkOne("s1_unlocked_f2", 32'(locked_o), 0);
    driveFrame(10, -1, 1'b1, -1);
    checkOne("s1_unlocked_f3", 32'(locked_o), 0);
    driveFrame(10, -1, 1'b1, -1);
    checkOne("s1_locked", 32'(locked_o), 1);
    checkOne("s1_ah_locked", 32'(lk_ah), 1);
    checkOne("s1_h_total", 32'(h_total_o), 20);
    checkOne("s1_v_total", 32'(v_total_o), 10);

    $display("[TB] one short line while locked");
    err_pulses = 0;
    driveFrame(10, $urandom_range(1, 8), 1'b0, -1);
    checkOne("s2_unlocked", 32'(locked_o), 0);
    for (int f = 0; f < 3; f++) driveFrame(10, -1, 1'b0, -1);
    checkOne("s2_err_pulses", err_pulses, 1);
    checkOne("s2_relocked", 32'(locked_o), 1);

    $display("[TB] HS missing long enough to saturate");
    err_pulses = 0;
    driveFrame(3, -1, 1'b0, -1);
    driveIdle(4200);
    checkOne("s3_err_pulses", err_pulses, 1);
    checkOne("s3_unlocked", 32'(locked_o), 0);
    checkOne("s3_x_hold", 32'(x_o), CMAX);
    checkOne("s3_h_total", 32'(h_total_o), 20);
    for (int f = 0; f < 4; f++) driveFrame(10, -1, 1'b0, -1);
    checkOne("s3_relocked", 32'(locked_o), 1);

    $display("[TB] one-cycle reset mid-frame while locked");
    err_pulses = 0;
    driveFrame(10, -1, 1'b0, $urandom_range(45, 150));
    for (int f = 0; f < 3; f++) driveFrame(10, -1, 1'b0, -1);
    checkOne("s5_unlocked_f3", 32'(locked_o), 0);
    driveFrame(10, -1, 1'b0, -1);
    checkOne("s5_relocked", 32'(locked_o), 1);
    checkOne("s5_no_err", err_pulses, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_rx.md
# vga_timing_rx

Receive-side counterpart of the board display interface: passively samples a VGA-style stream (RGB, HS, VS) in the pixel clock domain, measures line/frame geometry, recovers pixel coordinates and reports lock. It sits on the consumer end of the VGA signal group (loopback self-test, on-board capture or scaler input) and doubles as an in-system timing checker for the pong video generator.

## Interface
- RGB_W, display_pkg::RGB_W, RGB bus width
- CNT_W, 12, width of all horizontal/vertical counters and measurements
- HS_ACTIVE_LOW, 1, HS asserted level is 0 when 1
- VS_ACTIVE_LOW, 1, VS asserted level is 0 when 1
- LOCK_FRAMES, 2, consecutive identical frames required for lock (≥1)
- clk  in  1  pixel clock; sole clock
- rst_n  in  1  synchronous, active-low reset
- vga_rgb  in  RGB_W  pixel data
- vga_hs  in  1  horizontal sync
- vga_vs  in  1  vertical sync
- rgb_o  out  RGB_W  pixel data aligned with x_o/y_o
- x_o  out  CNT_W  clocks since last HS trailing edge
- y_o  out  CNT_W  lines since last VS trailing edge
- frame_start_o  out  1  one-cycle pulse on VS trailing edge
- h_total_o  out  CNT_W  last measured line length (clocks)
- v_total_o  out  CNT_W  last measured frame length (lines)
- locked_o  out  1  geometry stable
- sync_err_o  out  1  one-cycle pulse on loss of lock

## Operation
- Stage 1 registers rgb/hs/vs and normalises sync to active-high (XOR with *_ACTIVE_LOW); previous normalised values kept for edge detect. Leading edge = 0→1, trailing = 1→0.
- h_cnt: increments every clock, saturates at all-ones; on HS leading edge h_meas ← h_cnt+1, h_cnt ← 0.
- x counter: 0 on HS trailing edge cycle, else +1, saturating.
- line counter: +1 on each HS leading edge, saturating; on VS leading edge v_meas ← line counter, line counter ← 0.
- y counter: 0 on VS trailing edge; +1 on each later HS trailing edge; saturating.
- h_total_o / v_total_o updated from h_meas / v_meas at the respective leading edge.
- FSM (UNLOCKED, TRACK, LOCKED), match counter up to LOCK_FRAMES:
  - UNLOCKED: first VS leading edge → TRACK, reference (h_ref, v_ref) ← current measurements, match = 0.
  - TRACK: each HS leading edge with h_meas ≠ h_ref → UNLOCKED. Each VS leading edge: v_meas = v_ref → match+1, reaching LOCK_FRAMES → LOCKED; else reference reload, match = 0, stay TRACK.
  - LOCKED: h_meas ≠ h_ref, v_meas ≠ v_ref, or h_cnt saturation (no HS) → UNLOCKED with sync_err_o pulse.
- Simultaneous HS and VS leading edges in one cycle: HS processing (h_meas, line increment) first, then VS uses the incremented line count.
- h_cnt saturation in UNLOCKED/TRACK → UNLOCKED, no sync_err_o.
- locked_o = (state == LOCKED). rgb/x/y pass through regardless of lock.

## Timing
- rgb_o, x_o, y_o, frame_start_o: 2 cycles after the pins (stage 1 + output register), mutually aligned.
- h_total_o/v_total_o, locked_o, sync_err_o: registered, valid the cycle after stage-1 edge detect (2 cycles from pin).
- Lock asserts at the VS leading edge closing the LOCKED_FRAMES-th matching frame after reference; minimum LOCK_FRAMES+1 complete frames from reset.
- Reset (any cycle, including mid-frame): every output 0, all counters/refs 0, state UNLOCKED, sync history = deasserted; first observed edge after reset is only a candidate reference, never an error.

## Structure
- display_pkg: add vga_rx_state_t enum (UNLOCKED, TRACK, LOCKED); reuse RGB_W.
- One sub-module natural: sync_edge_det (polarity normalise, register, leading/trailing pulses), instantiated for HS and VS.

## Test plan
- Reduced timing (line 20 clk, HS 3; frame 10 lines, VS 2), active-low → h_total_o=20, v_total_o=10, locked_o rises at end of 3rd frame, x_o 0..19 aligned to HS trailing edge, y_o 0 after VS ends.
- Locked, one line shortened to 19 clk → single sync_err_o pulse, locked_o 0, relock after 3 clean frames.
- Locked, HS held inactive 4096 clk → h_cnt saturates, sync_err_o pulse, locked_o 0, x_o holds 4095.
- HS_ACTIVE_LOW=0, VS_ACTIVE_LOW=0 with inverted stimulus → identical results to scenario 1.
- rst_n low for 1 cycle mid-frame while locked → all outputs 0 next cycle, locked_o returns after 3 full frames.
- vga_rgb driven = x pattern → rgb_o equals x_o (mod 2^RGB_W) every cycle, confirming 2-cycle alignment.
